// File: rtl/player_ctrl_fsm.sv
// Player controller for the crossing game: grid movement from held switches, collision against
// N cars, PLAY/HIT/OVER life handling, saturating BCD level and exported car speed.
module player_ctrl_fsm #(
   parameter int unsigned N_CARS     = 8,
   parameter int unsigned LIVES      = 4,
   parameter int unsigned H_DISP     = 640,
   parameter int unsigned V_DISP     = 480,
   parameter int unsigned PLAYER_W   = 32,
   parameter int unsigned PLAYER_H   = 32,
   parameter int unsigned CAR_W      = 64,
   parameter int unsigned CAR_H      = 32,
   parameter int unsigned STEP       = 32,
   parameter int unsigned MOVE_TICKS = 2500000,
   parameter int unsigned HIT_HOLD   = 25000000,
   parameter int unsigned SPEED_MAX  = 31
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [3:0]            SW,
   input  logic [10*N_CARS-1:0]  car_x,
   input  logic [10*N_CARS-1:0]  car_y,
   output logic [9:0]            player_x,
   output logic [9:0]            player_y,
   output logic [LIVES-1:0]      lives,
   output logic [7:0]            level_bcd,
   output logic [4:0]            speed_car,
   output logic [1:0]            state,
   output logic                  hit,
   output logic                  level_up
);

   localparam int unsigned MCW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam int unsigned HCW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

   localparam logic [MCW-1:0]   MOVE_MAX   = MCW'(MOVE_TICKS - 1);
   localparam logic [HCW-1:0]   HOLD_MAX   = HCW'(HIT_HOLD - 1);
   localparam logic [9:0]       SPAWN_X    = 10'(H_DISP / 2);
   localparam logic [9:0]       SPAWN_Y    = 10'(V_DISP - PLAYER_H);
   localparam logic [9:0]       STEP10     = 10'(STEP);
   localparam logic [10:0]      STEP11     = 11'(STEP);
   localparam logic [10:0]      PW11       = 11'(PLAYER_W);
   localparam logic [10:0]      PH11       = 11'(PLAYER_H);
   localparam logic [10:0]      CW11       = 11'(CAR_W);
   localparam logic [10:0]      CH11       = 11'(CAR_H);
   localparam logic [10:0]      HD11       = 11'(H_DISP);
   localparam logic [10:0]      VD11       = 11'(V_DISP);
   localparam logic [4:0]       SPEED_SAT  = 5'(SPEED_MAX);
   localparam logic [LIVES-1:0] LIVES_FULL = {LIVES{1'b1}};
   localparam logic [LIVES-1:0] LIVES_LAST = LIVES'(1);

   typedef enum logic [1:0] {
      StPlay = 2'd0,
      StHit  = 2'd1,
      StOver = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [9:0]       px_q, px_d, py_q, py_d;
   logic [LIVES-1:0] lives_q, lives_d;
   logic [7:0]       level_q, level_d;
   logic [4:0]       speed_q, speed_d;
   logic             hit_q, hit_d;
   logic             level_up_q, level_up_d;
   logic             hit_det_q, hit_det_d;
   logic [MCW-1:0]   move_cnt_q, move_cnt_d;
   logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

   logic [10:0] px11, py11;
   logic        can_up, can_down, can_left, can_right;
   logic        overlap;
   logic [7:0]  level_inc;
   logic        restart;

   assign px11      = {1'b0, px_q};
   assign py11      = {1'b0, py_q};
   assign can_up    = py11 >= STEP11;
   assign can_down  = (py11 + PH11 + STEP11) <= VD11;
   assign can_left  = px11 >= STEP11;
   assign can_right = (px11 + PW11 + STEP11) <= HD11;
   assign restart   = (SW == 4'b1111);

   // Rectangle overlap against every car, all at 11 bits so edge sums never wrap.
   always_comb begin
      logic [10:0] cx, cy;
      overlap = 1'b0;
      cx      = '0;
      cy      = '0;
      for (int i = 0; i < int'(N_CARS); i++) begin
         cx = {1'b0, car_x[10*i +: 10]};
         cy = {1'b0, car_y[10*i +: 10]};
         if ((px11 + PW11 > cx) && (px11 < cx + CW11) &&
             (py11 + PH11 > cy) && (py11 < cy + CH11)) begin
            overlap = 1'b1;
         end
      end
   end

   always_comb begin
      if (level_q[3:0] == 4'd9) begin
         level_inc = {level_q[7:4] + 4'd1, 4'd0};
      end else begin
         level_inc = {level_q[7:4], level_q[3:0] + 4'd1};
      end
   end

   always_comb begin
      state_d    = state_q;
      px_d       = px_q;
      py_d       = py_q;
      lives_d    = lives_q;
      level_d    = level_q;
      speed_d    = speed_q;
      hit_d      = 1'b0;
      level_up_d = 1'b0;
      hit_det_d  = overlap;
      hold_cnt_d = hold_cnt_q;
      move_cnt_d = (move_cnt_q == MOVE_MAX) ? move_cnt_q : move_cnt_q + MCW'(1);

      if (restart) begin
         state_d    = StPlay;
         px_d       = SPAWN_X;
         py_d       = SPAWN_Y;
         lives_d    = LIVES_FULL;
         level_d    = 8'h00;
         speed_d    = 5'd0;
         hit_det_d  = 1'b0;
         hold_cnt_d = '0;
         move_cnt_d = '0;
      end else begin
         case (state_q)
            StPlay: begin
               if (hit_det_q) begin
                  lives_d    = lives_q >> 1;
                  hit_d      = 1'b1;
                  px_d       = SPAWN_X;
                  py_d       = SPAWN_Y;
                  move_cnt_d = '0;
                  if (lives_q == LIVES_LAST) begin
                     state_d = StOver;
                  end else begin
                     state_d    = StHit;
                     hold_cnt_d = HOLD_MAX;
                  end
               end else if (py_q == 10'd0) begin
                  // Level saturates at 99 and speed stops advancing with it.
                  if (level_q != 8'h99) begin
                     level_d = level_inc;
                     if (speed_q != SPEED_SAT) speed_d = speed_q + 5'd1;
                  end
                  level_up_d = 1'b1;
                  px_d       = SPAWN_X;
                  py_d       = SPAWN_Y;
               end else if ((move_cnt_q == MOVE_MAX) && (SW != 4'b0000)) begin
                  move_cnt_d = '0;
                  if (SW[0]) begin
                     if (can_up) py_d = py_q - STEP10;
                  end else if (SW[1]) begin
                     if (can_down) py_d = py_q + STEP10;
                  end else if (SW[2]) begin
                     if (can_left) px_d = px_q - STEP10;
                  end else begin
                     if (can_right) px_d = px_q + STEP10;
                  end
               end
            end
            StHit: begin
               if (hold_cnt_q == '0) begin
                  state_d = StPlay;
               end else begin
                  hold_cnt_d = hold_cnt_q - HCW'(1);
               end
            end
            StOver: begin
               px_d = SPAWN_X;
               py_d = SPAWN_Y;
            end
            default: state_d = StPlay;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StPlay;
         px_q       <= SPAWN_X;
         py_q       <= SPAWN_Y;
         lives_q    <= LIVES_FULL;
         level_q    <= 8'h00;
         speed_q    <= 5'd0;
         hit_q      <= 1'b0;
         level_up_q <= 1'b0;
         hit_det_q  <= 1'b0;
         move_cnt_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         px_q       <= px_d;
         py_q       <= py_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         speed_q    <= speed_d;
         hit_q      <= hit_d;
         level_up_q <= level_up_d;
         hit_det_q  <= hit_det_d;
         move_cnt_q <= move_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign player_x  = px_q;
   assign player_y  = py_q;
   assign lives     = lives_q;
   assign level_bcd = level_q;
   assign speed_car = speed_q;
   assign state     = state_q;
   assign hit       = hit_q;
   assign level_up  = level_up_q;

endmodule

// File: tb/tb_player_ctrl_fsm.sv
// Bench for player_ctrl_fsm: directed scenarios plus random stimulus, all checked against a
// cycle-level game model kept in plain integers (life count, decimal level).
module tb_player_ctrl_fsm;

   localparam int N    = 8;
   localparam int LV   = 4;
   localparam int MT   = 4;
   localparam int HH   = 8;
   localparam int SMAX = 31;
   localparam int HD   = 640;
   localparam int VD   = 480;
   localparam int PW   = 32;
   localparam int PH   = 32;
   localparam int CW   = 64;
   localparam int CH   = 32;
   localparam int ST   = 32;
   localparam int SPX  = HD / 2;
   localparam int SPY  = VD - PH;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      sw = 4'd0;
   logic [9:0]      cx [N];
   logic [9:0]      cy [N];
   logic [10*N-1:0] car_x, car_y;
   logic [9:0]      player_x, player_y;
   logic [LV-1:0]   lives;
   logic [7:0]      level_bcd;
   logic [4:0]      speed_car;
   logic [1:0]      state;
   logic            hit, level_up;
   logic [40:0]     dut_vec;

   int checks = 0;
   int errors = 0;

   int m_px, m_py, m_lives, m_level, m_speed, m_state, m_hit, m_lup, m_mcnt, m_hold, m_hdet;

   always #5 clk = ~clk;

   always_comb begin
      car_x = '0;
      car_y = '0;
      for (int i = 0; i < N; i++) begin
         car_x[10*i +: 10] = cx[i];
         car_y[10*i +: 10] = cy[i];
      end
   end

   assign dut_vec = {player_x, player_y, lives, level_bcd, speed_car, state, hit, level_up};

   player_ctrl_fsm #(
      .N_CARS(N), .LIVES(LV), .H_DISP(HD), .V_DISP(VD), .PLAYER_W(PW), .PLAYER_H(PH),
      .CAR_W(CW), .CAR_H(CH), .STEP(ST), .MOVE_TICKS(MT), .HIT_HOLD(HH), .SPEED_MAX(SMAX)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .SW(sw), .car_x(car_x), .car_y(car_y),
      .player_x(player_x), .player_y(player_y), .lives(lives), .level_bcd(level_bcd),
      .speed_car(speed_car), .state(state), .hit(hit), .level_up(level_up)
   );

   function automatic bit ov_any(int px, int py);
      for (int i = 0; i < N; i++) begin
         if (px + PW > int'(cx[i]) && px < int'(cx[i]) + CW &&
             py + PH > int'(cy[i]) && py < int'(cy[i]) + CH) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [40:0] exp_vec();
      logic [3:0] th;
      logic [7:0] bcd;
      th  = 4'((1 << m_lives) - 1);
      bcd = {4'(m_level / 10), 4'(m_level % 10)};
      return {10'(m_px), 10'(m_py), th, bcd, 5'(m_speed), 2'(m_state), 1'(m_hit), 1'(m_lup)};
   endfunction

   task automatic model_reset();
      m_px = SPX; m_py = SPY; m_lives = LV; m_level = 0; m_speed = 0; m_state = 0;
      m_hit = 0; m_lup = 0; m_mcnt = 0; m_hold = 0; m_hdet = 0;
   endtask

   // Game rules for one clock edge; state 0=PLAY, 1=HIT, 2=OVER.
   task automatic model_step();
      bit ov;
      int mc;
      ov    = ov_any(m_px, m_py);
      mc    = (m_mcnt < MT - 1) ? m_mcnt + 1 : m_mcnt;
      m_hit = 0;
      m_lup = 0;
      if (sw == 4'hf) begin
         model_reset();
         return;
      end
      if (m_state == 0) begin
         if (m_hdet != 0) begin
            m_lives--; m_hit = 1; m_px = SPX; m_py = SPY; mc = 0;
            if (m_lives == 0) m_state = 2;
            else begin m_state = 1; m_hold = HH - 1; end
         end else if (m_py == 0) begin
            if (m_level < 99) begin
               m_level++;
               if (m_speed < SMAX) m_speed++;
            end
            m_lup = 1; m_px = SPX; m_py = SPY;
         end else if (m_mcnt == MT - 1 && sw != 0) begin
            mc = 0;
            if (sw[0]) begin if (m_py >= ST) m_py -= ST; end
            else if (sw[1]) begin if (m_py + PH + ST <= VD) m_py += ST; end
            else if (sw[2]) begin if (m_px >= ST) m_px -= ST; end
            else begin if (m_px + PW + ST <= HD) m_px += ST; end
         end
      end else if (m_state == 1) begin
         if (m_hold == 0) m_state = 0;
         else m_hold--;
      end else begin
         m_px = SPX; m_py = SPY;
      end
      m_mcnt = mc;
      m_hdet = ov;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cars_far();
      for (int i = 0; i < N; i++) begin cx[i] = 10'd1000; cy[i] = 10'd1000; end
   endtask

   task automatic test_reset();
      cars_far();
      model_reset();
      #12;
      checks++;
      if (dut_vec !== {10'd320, 10'd448, 4'hf, 8'h00, 5'd0, 2'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset: got %h want %h", dut_vec, exp_vec());
      end
      @(negedge clk) rst_n = 1'b1;
      for (int t = 0; t < 5; t++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_idle t=%0d: got %h want %h", t, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_move();
      sw = 4'b0001;
      for (int t = 1; t <= 12; t++) begin
         tick();
         checks++;
         if (player_y !== 10'(448 - 32 * ((t + 3) / 4)) || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL move_up t=%0d: got y=%0d vec=%h want y=%0d vec=%h", t, player_y,
                     dut_vec, 448 - 32 * ((t + 3) / 4), exp_vec());
         end
      end
   endtask

   task automatic test_goal();
      int n;
      n = 0;
      while (m_py != 0 && n < 100) begin
         tick(); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL goal_climb: got %h want %h", dut_vec, exp_vec());
         end
      end
      checks++;
      if (player_y !== 10'd0) begin
         errors++; $display("FAIL goal_reach: got y=%0d want y=0", player_y);
      end
      tick();
      checks++;
      if ({level_up, level_bcd, speed_car, player_x, player_y} !==
          {1'b1, 8'h01, 5'd1, 10'd320, 10'd448}) begin
         errors++;
         $display("FAIL goal_level: got lu=%b lvl=%h spd=%0d x=%0d y=%0d want 1 01 1 320 448",
                  level_up, level_bcd, speed_car, player_x, player_y);
      end
      sw = 4'b0000;
      tick();
      checks++;
      if (level_up !== 1'b0 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL goal_pulse: got %h want %h", dut_vec, exp_vec());
      end
      tick();
   endtask

   task automatic test_hit_hold();
      cx[3] = 10'd320; cy[3] = 10'd448;
      tick();
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL hit_early: got %b want 0", hit); end
      tick();
      checks++;
      if ({hit, lives, state} !== {1'b1, 4'b0111, 2'd1} || dut_vec !== exp_vec()) begin
         errors++;
         $display("FAIL hit_first: got hit=%b lives=%b st=%0d want 1 0111 1", hit, lives, state);
      end
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (hit !== 1'b0 || state !== 2'd1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL hit_hold k=%0d: got hit=%b st=%0d want 0 1", k, hit, state);
         end
      end
      cx[3] = 10'd1000; cy[3] = 10'd1000;
      tick();
      checks++;
      if (state !== 2'd0 || hit !== 1'b0) begin
         errors++; $display("FAIL hit_resume: got st=%0d hit=%b want 0 0", state, hit);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (hit !== 1'b0 || lives !== 4'b0111 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL hit_after: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_game_over();
      int idx, n;
      idx = 0; n = 0;
      cx[3] = 10'd320; cy[3] = 10'd448;
      while (m_state != 2 && n < 100) begin
         tick(); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL over_seq: got %h want %h", dut_vec, exp_vec());
         end
         if (hit === 1'b1) begin
            checks++;
            if (lives !== 4'((1 << (2 - idx)) - 1)) begin
               errors++;
               $display("FAIL over_lives idx=%0d: got %b want %b", idx, lives,
                        4'((1 << (2 - idx)) - 1));
            end
            idx++;
         end
      end
      checks++;
      if (idx != 3 || state !== 2'd2 || lives !== 4'b0000) begin
         errors++;
         $display("FAIL over_state: got hits=%0d st=%0d lives=%b want 3 2 0000", idx, state, lives);
      end
      cx[3] = 10'd1000; cy[3] = 10'd1000;
      sw = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (player_y !== 10'd448 || state !== 2'd2 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL over_frozen: got %h want %h", dut_vec, exp_vec());
         end
      end
      sw = 4'b1111;
      tick();
      checks++;
      if ({lives, level_bcd, speed_car, state} !== {4'hf, 8'h00, 5'd0, 2'd0}) begin
         errors++;
         $display("FAIL restart: got lives=%b lvl=%h spd=%0d st=%0d want 1111 00 0 0",
                  lives, level_bcd, speed_car, state);
      end
      sw = 4'b0000;
   endtask

   task automatic test_hit_goal_same();
      int n;
      n = 0;
      sw = 4'b0001;
      while (!(m_py == 32 && m_mcnt == MT - 1) && n < 200) begin
         tick(); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL hg_climb: got %h want %h", dut_vec, exp_vec());
         end
      end
      cx[0] = 10'd320; cy[0] = 10'd16;
      tick();
      checks++;
      if (player_y !== 10'd0) begin
         errors++; $display("FAIL hg_top: got y=%0d want 0", player_y);
      end
      tick();
      checks++;
      if ({hit, level_up, level_bcd, player_y, lives} !== {1'b1, 1'b0, 8'h00, 10'd448, 4'b0111})
      begin
         errors++;
         $display("FAIL hit_beats_goal: got hit=%b lu=%b lvl=%h y=%0d lives=%b want 1 0 00 448 0111",
                  hit, level_up, level_bcd, player_y, lives);
      end
      cx[0] = 10'd1000; cy[0] = 10'd1000;
      sw = 4'b0000;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL hg_after: got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_bounds();
      sw = 4'b1111; tick();
      sw = 4'b0100;
      for (int k = 0; k < 60; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL bound_left_seq: got %h want %h", dut_vec, exp_vec());
         end
      end
      checks++;
      if (player_x !== 10'd0) begin errors++; $display("FAIL bound_left: got x=%0d want 0", player_x); end
      sw = 4'b1000;
      for (int k = 0; k < 100; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL bound_right_seq: got %h want %h", dut_vec, exp_vec());
         end
      end
      checks++;
      if (player_x !== 10'd608) begin
         errors++; $display("FAIL bound_right: got x=%0d want 608", player_x);
      end
      sw = 4'b0000;
   endtask

   task automatic test_level_sat();
      int n, extra;
      bit seen_carry;
      logic [7:0] prev;
      n = 0; extra = 0; seen_carry = 1'b0;
      sw = 4'b1111; tick();
      prev = level_bcd;
      sw = 4'b0001;
      while (extra < 3 && n < 9000) begin
         tick(); n++;
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL level_seq n=%0d: got %h want %h", n, dut_vec, exp_vec());
         end
         if (prev == 8'h09 && level_bcd != prev) begin
            seen_carry = 1'b1;
            checks++;
            if (level_bcd !== 8'h10) begin
               errors++; $display("FAIL bcd_carry: got %h want 10", level_bcd);
            end
         end
         if (m_level == 99 && m_lup == 1) extra++;
         prev = level_bcd;
      end
      checks++;
      if (!seen_carry || level_bcd !== 8'h99 || speed_car !== 5'd31) begin
         errors++;
         $display("FAIL level_sat: got carry=%b lvl=%h spd=%0d want 1 99 31", seen_carry,
                  level_bcd, speed_car);
      end
      sw = 4'b0000;
   endtask

   task automatic test_async_reset();
      sw = 4'b1111; tick(); sw = 4'b0000;
      cx[2] = 10'd320; cy[2] = 10'd448;
      for (int k = 0; k < 4; k++) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== {10'd320, 10'd448, 4'hf, 8'h00, 5'd0, 2'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset: got %h want %h", dut_vec, exp_vec());
      end
      cx[2] = 10'd1000; cy[2] = 10'd1000;
      sw = 4'b0001;
      @(negedge clk) rst_n = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         tick();
         checks++;
         if (player_y !== ((t < 4) ? 10'd448 : 10'd416) || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_counter t=%0d: got y=%0d want %0d", t, player_y,
                     (t < 4) ? 448 : 416);
         end
      end
      sw = 4'b0000;
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            sw = ($urandom_range(0, 99) == 0) ? 4'hf : 4'($urandom_range(0, 14));
         end
         if ($urandom_range(0, 19) == 0) begin
            cars_far();
            for (int i = 0; i < 2; i++) begin
               cx[$urandom_range(0, N - 1)] = 10'($urandom_range(0, 700));
               cy[$urandom_range(0, N - 1)] = 10'($urandom_range(0, 500));
            end
         end
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, exp_vec());
         end
      end
      sw = 4'b0000;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_move();
      test_goal();
      test_hit_hold();
      test_game_over();
      test_hit_goal_same();
      test_bounds();
      test_level_sat();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
